hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit_pkg.sv | 16 +
 rtl/hazard_stall_unit_compare.sv | 18 +
 rtl/hazard_stall_unit.sv | 121 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared state type and constants for the load-use stall unit
package hazard_stall_unit_pkg;

    // IDLE evaluates hazards combinationally; HOLD issues the remaining bubbles of a multi-cycle stall
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Register 0 is hardwired to zero and never carries a real dependency
    localparam int REG_ZERO = 0;

    // Width of the remaining-bubble down-counter (covers LOAD_STALL_CYCLES up to 7)
    localparam int REMAIN_W = 3;

endpackage

// File: rtl/hazard_stall_unit_compare.sv
// rtl/hazard_stall_unit_compare.sv - per-operand load-use register match
module hazard_compare
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_uses,
    input  logic [REG_ADDR_W-1:0] i_src_addr,
    input  logic [REG_ADDR_W-1:0] i_dst_addr,
    output logic                  o_match
);

    // A source operand depends on the load only if it is actually read and the destination is not register 0
    assign o_match = i_uses
                   & (i_src_addr == i_dst_addr)
                   & (i_dst_addr != REG_ADDR_W'(REG_ZERO));

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use hazard stall/bubble FSM; HAZARD_STALL_STATS_EN adds o_stall_count
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int STAT_W            = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_dst_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rt_addr,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    input  logic                  i_flush,
    input  logic                  i_mem_busy,
    output logic                  o_stall,
    output logic                  o_bubble
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [STAT_W-1:0]     o_stall_count
`endif
);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_stall_cycles
        $error("LOAD_STALL_CYCLES must be in 1..7");
    end
    if (STAT_W < 1) begin : g_bad_stat_w
        $error("STAT_W must be at least 1");
    end

    logic                w_match_rs;
    logic                w_match_rt;
    logic                w_hazard;
    logic                w_stall;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [REMAIN_W-1:0] r_remain;
    logic [REMAIN_W-1:0] w_remain_nxt;

    hazard_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs (
        .i_uses     (i_id_uses_rs),
        .i_src_addr (i_id_rs_addr),
        .i_dst_addr (i_ex_dst_addr),
        .o_match    (w_match_rs)
    );

    hazard_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rt (
        .i_uses     (i_id_uses_rt),
        .i_src_addr (i_id_rt_addr),
        .i_dst_addr (i_ex_dst_addr),
        .o_match    (w_match_rt)
    );

    assign w_hazard = i_ex_valid & i_ex_is_load & (w_match_rs | w_match_rt);

    // State and bubble down-counter; mem_busy freezes both, flush/hazard steer via next-state logic
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    // Next-state and stall decode; a flush squashes the stalled instruction so no bubble is needed
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_hazard & ~i_flush;
                if (w_hazard && !i_flush && !i_mem_busy && (LOAD_STALL_CYCLES > 1)) begin
                    w_state_nxt  = ST_HOLD;
                    w_remain_nxt = REMAIN_W'(LOAD_STALL_CYCLES - 1);
                end
            end
            ST_HOLD: begin
                w_stall = ~i_flush;
                if (!i_mem_busy) begin
                    if (i_flush || (r_remain == REMAIN_W'(1))) begin
                        w_state_nxt  = ST_IDLE;
                        w_remain_nxt = '0;
                    end else begin
                        w_remain_nxt = r_remain - REMAIN_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_remain_nxt = '0;
            end
        endcase
    end

    // Reset overrides the combinational IDLE decode so nothing stalls while reset is held
    assign o_stall  = w_stall & ~i_reset;
    assign o_bubble = w_stall & ~i_reset;

`ifdef HAZARD_STALL_STATS_EN
    logic [STAT_W-1:0] r_stall_count;

    // Count bubbles that actually advance the pipeline, saturating at all-ones
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_stall_count <= '0;
        end else if (o_bubble && !i_mem_busy && !(&r_stall_count)) begin
            r_stall_count <= r_stall_count + STAT_W'(1);
        end
    end

    assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit (1- and 3-cycle builds)
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid, ex_is_load;
    logic [4:0] ex_dst, rs, rt;
    logic       uses_rs, uses_rt, flush, busy;
    logic       s1, b1, s3, b3;
`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] cnt1, cnt3;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int m1_pend, m3_pend, m1_cnt, m3_cnt;

    always #5 clk = ~clk;

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .STAT_W(16)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load),
        .i_ex_dst_addr(ex_dst), .i_id_rs_addr(rs), .i_id_rt_addr(rt),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_flush(flush), .i_mem_busy(busy),
        .o_stall(s1), .o_bubble(b1)
`ifdef HAZARD_STALL_STATS_EN
        , .o_stall_count(cnt1)
`endif
    );

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .STAT_W(16)) u_dut3 (
        .i_clock(clk), .i_reset(rst), .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load),
        .i_ex_dst_addr(ex_dst), .i_id_rs_addr(rs), .i_id_rt_addr(rt),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_flush(flush), .i_mem_busy(busy),
        .o_stall(s3), .o_bubble(b3)
`ifdef HAZARD_STALL_STATS_EN
        , .o_stall_count(cnt3)
`endif
    );

    task automatic set_in(input logic v, input logic ld, input logic [4:0] d, input logic [4:0] a_rs,
                          input logic [4:0] a_rt, input logic u_rs, input logic u_rt,
                          input logic fl, input logic bz);
        ex_valid = v; ex_is_load = ld; ex_dst = d; rs = a_rs; rt = a_rt;
        uses_rs = u_rs; uses_rt = u_rt; flush = fl; busy = bz;
    endtask

    // Reference: a load-use dependency on a non-zero register
    function automatic bit ref_hazard();
        return ex_valid && ex_is_load && (ex_dst != 5'd0) &&
               ((uses_rs && rs == ex_dst) || (uses_rt && rt == ex_dst));
    endfunction

    // Reference: pend = bubbles still owed after the current one
    function automatic bit ref_out(input int pend);
        if (rst) return 1'b0;
        if (pend > 0) return !flush;
        return ref_hazard() && !flush;
    endfunction

    task automatic advance(input int lsc, input bit out, inout int pend, inout int cnt);
        if (!busy) begin
            if (out && cnt < 65535) cnt++;
            if (pend > 0) pend = flush ? 0 : pend - 1;
            else if (out) pend = lsc - 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        m1_pend = 0; m3_pend = 0; m1_cnt = 0; m3_cnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(1, 1, 5, 5, 0, 1, 0, 0, 0);
        #1;
        n_checks++; if (s1 !== 1'b0) begin n_fail++; $display("FAIL reset_stall1: got %b expected 0", s1); end
        n_checks++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL reset_bubble1: got %b expected 0", b1); end
        n_checks++; if (s3 !== 1'b0) begin n_fail++; $display("FAIL reset_stall3: got %b expected 0", s3); end
        n_checks++; if (b3 !== 1'b0) begin n_fail++; $display("FAIL reset_bubble3: got %b expected 0", b3); end
`ifdef HAZARD_STALL_STATS_EN
        n_checks++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt3); end
`endif
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_single_bubble();
        do_reset();
        @(negedge clk);
        set_in(1, 1, 5, 5, 9, 1, 0, 0, 0);
        #1;
        n_checks++; if (s1 !== 1'b1) begin n_fail++; $display("FAIL single_stall_c0: got %b expected 1", s1); end
        n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL single_bubble_c0: got %b expected 1", b1); end
        @(negedge clk);
        set_in(0, 0, 0, 5, 9, 1, 0, 0, 0);
        #1;
        n_checks++; if (s1 !== 1'b0) begin n_fail++; $display("FAIL single_stall_c1: got %b expected 0", s1); end
        n_checks++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL single_bubble_c1: got %b expected 0", b1); end
    endtask

    task automatic test_three_bubbles();
        logic exp_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) set_in(1, 1, 5, 5, 9, 1, 0, 0, 0);
            else        set_in(0, 0, 0, 5, 9, 1, 0, 0, 0);
            #1;
            n_checks++;
            if (s3 !== exp_seq[i] || b3 !== exp_seq[i]) begin
                n_fail++; $display("FAIL three_cycle[%0d]: stall=%b bubble=%b expected %b", i, s3, b3, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reg_zero();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(1, 1, 0, 0, 0, 0, 1, 0, 0);
            #1;
            n_checks++;
            if (s1 !== 1'b0 || s3 !== 1'b0) begin
                n_fail++; $display("FAIL reg_zero[%0d]: stall1=%b stall3=%b expected 0", i, s1, s3);
            end
        end
    endtask

    task automatic test_mem_busy();
        logic exp_seq  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic busy_seq [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) set_in(1, 1, 5, 0, 5, 0, 1, 0, busy_seq[i]);
            else        set_in(0, 0, 0, 0, 5, 0, 1, 0, busy_seq[i]);
            #1;
            n_checks++;
            if (s3 !== exp_seq[i]) begin
                n_fail++; $display("FAIL mem_busy[%0d]: stall=%b expected %b", i, s3, exp_seq[i]);
            end
        end
`ifdef HAZARD_STALL_STATS_EN
        n_checks++; if (cnt3 !== 16'd3) begin n_fail++; $display("FAIL mem_busy_count: got %0d expected 3", cnt3); end
`endif
    endtask

    task automatic test_flush_and_abort();
        do_reset();
        @(negedge clk); set_in(1, 1, 5, 5, 0, 1, 0, 0, 0); #1;
        n_checks++; if (s3 !== 1'b1) begin n_fail++; $display("FAIL flush_enter: got %b expected 1", s3); end
        @(negedge clk); set_in(0, 0, 0, 5, 0, 1, 0, 1, 0); #1;
        n_checks++; if (s3 !== 1'b0 || b3 !== 1'b0) begin n_fail++; $display("FAIL flush_hold: stall=%b bubble=%b expected 0", s3, b3); end
        @(negedge clk); set_in(0, 0, 0, 5, 0, 1, 0, 0, 0); #1;
        n_checks++; if (s3 !== 1'b0) begin n_fail++; $display("FAIL flush_idle_after: got %b expected 0", s3); end
        @(negedge clk); set_in(1, 1, 5, 5, 0, 1, 0, 1, 0); #1;
        n_checks++; if (s3 !== 1'b0 || s1 !== 1'b0) begin n_fail++; $display("FAIL flush_wins: stall3=%b stall1=%b expected 0", s3, s1); end
        @(negedge clk); set_in(1, 1, 5, 5, 0, 1, 0, 0, 0); #1;
        n_checks++; if (s3 !== 1'b1) begin n_fail++; $display("FAIL flush_no_state: got %b expected 1", s3); end
        @(negedge clk); set_in(0, 0, 0, 5, 0, 1, 0, 0, 0); #1;
        n_checks++; if (s3 !== 1'b1) begin n_fail++; $display("FAIL abort_in_hold: got %b expected 1", s3); end
        @(negedge clk); rst = 1'b1; #1;
        n_checks++; if (s3 !== 1'b0 || b3 !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: stall=%b bubble=%b expected 0", s3, b3); end
`ifdef HAZARD_STALL_STATS_EN
        n_checks++; if (cnt3 !== 16'd0) begin n_fail++; $display("FAIL abort_count: got %0d expected 0", cnt3); end
`endif
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (s3 !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b expected 0", s3); end
    endtask

    task automatic test_random();
        bit e1, e3;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            set_in(($urandom % 4) != 0, ($urandom % 3) != 0, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   ($urandom % 8) == 0, ($urandom % 4) == 0);
            #1;
            e1 = ref_out(m1_pend);
            e3 = ref_out(m3_pend);
            n_checks++;
            if (s1 !== e1 || b1 !== e1) begin
                n_fail++; $display("FAIL random1[%0d]: stall=%b bubble=%b expected %b", i, s1, b1, e1);
            end
            n_checks++;
            if (s3 !== e3 || b3 !== e3) begin
                n_fail++; $display("FAIL random3[%0d]: stall=%b bubble=%b expected %b", i, s3, b3, e3);
            end
`ifdef HAZARD_STALL_STATS_EN
            n_checks++;
            if (cnt1 !== 16'(m1_cnt) || cnt3 !== 16'(m3_cnt)) begin
                n_fail++; $display("FAIL random_count[%0d]: got %0d/%0d expected %0d/%0d", i, cnt1, cnt3, m1_cnt, m3_cnt);
            end
`endif
            advance(1, e1, m1_pend, m1_cnt);
            advance(3, e3, m3_pend, m3_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_single_bubble();
        test_three_bubbles();
        test_reg_zero();
        test_mem_busy();
        test_flush_and_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
